// File: rtl/door_access_ctrl.sv
// Multi-user door access controller: N programmable codes plus a fixed master key,
// failed-attempt counting with escalating alarm, timed unlock and a menu session.
module door_access_ctrl #(
    parameter int          PW_W          = 14,
    parameter int          N_USERS       = 4,
    parameter int unsigned MASTER_KEY    = 1111,
    parameter int unsigned INIT_CODE     = 1234,
    parameter int          MAX_FAILS     = 3,
    parameter int          ALARM_CYCLES  = 16,
    parameter int          UNLOCK_CYCLES = 8,
    parameter int          MENU_TIMEOUT  = 32,
    localparam int         UW            = $clog2(N_USERS),
    localparam int         FW            = $clog2(MAX_FAILS + 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            code_valid,
    input  logic [PW_W-1:0] code_in,
    input  logic            unlock_req,
    input  logic            change_req,
    input  logic            exit_req,
    input  logic [UW-1:0]   slot_sel,
    input  logic [PW_W-1:0] new_code,
    output logic            unlock_signal,
    output logic            lock_signal,
    output logic            alarm_signal,
    output logic [2:0]      state,
    output logic [FW-1:0]   fail_count,
    output logic [UW-1:0]   auth_id,
    output logic            auth_master,
    output logic            err
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MENU     = 3'd1;
    localparam logic [2:0] S_UNLOCKED = 3'd2;
    localparam logic [2:0] S_ALARM    = 3'd3;
    localparam logic [2:0] S_CHANGE   = 3'd4;

    localparam logic [PW_W-1:0] MASTER_W = PW_W'(MASTER_KEY);
    localparam logic [PW_W-1:0] INIT_W   = PW_W'(INIT_CODE);

    // Timer must hold the longest interval (top alarm level) without wrapping.
    localparam int ALARM_MAX = ALARM_CYCLES << 2;
    localparam int TMAX_A    = (ALARM_MAX > UNLOCK_CYCLES) ? ALARM_MAX : UNLOCK_CYCLES;
    localparam int TMAX      = (TMAX_A > MENU_TIMEOUT) ? TMAX_A : MENU_TIMEOUT;
    localparam int TW        = $clog2(TMAX + 1);

    logic [2:0]      state_reg, state_next;
    logic [TW-1:0]   timer_reg, timer_next;
    logic [FW-1:0]   fail_reg, fail_next;
    logic [1:0]      level_reg, level_next;
    logic [UW-1:0]   auth_id_reg, auth_id_next;
    logic            auth_master_reg, auth_master_next;
    logic [UW-1:0]   pend_slot_reg, pend_slot_next;
    logic [PW_W-1:0] pend_code_reg, pend_code_next;
    logic            unlock_reg, unlock_next;
    logic            alarm_reg, alarm_next;
    logic            err_reg, err_next;

    logic [PW_W-1:0] slot_code_reg [N_USERS];
    logic [N_USERS-1:0] slot_valid_reg;
    logic [N_USERS-1:0] match_vec;
    logic            match_any;
    logic [UW-1:0]   match_idx;
    logic            master_hit;
    logic            slot_write;
    logic            change_ok;
    logic            any_req;
    logic [TW-1:0]   alarm_len;
    logic [FW-1:0]   fail_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_USERS; gi++) begin : g_cmp
            assign match_vec[gi] = slot_valid_reg[gi] && (slot_code_reg[gi] == code_in);
        end
    endgenerate

    // Lowest matching slot index wins.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_USERS - 1; i >= 0; i--) begin
            if (match_vec[i]) begin
                match_any = 1'b1;
                match_idx = UW'(i);
            end
        end
    end

    assign master_hit = (code_in == MASTER_W);
    assign slot_write = (state_reg == S_CHANGE) && (pend_code_reg != MASTER_W);
    assign change_ok  = auth_master_reg || (slot_sel == auth_id_reg);
    assign any_req    = exit_req || unlock_req || change_req;
    assign alarm_len  = TW'(ALARM_CYCLES) << level_reg;
    assign fail_inc   = fail_reg + FW'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            slot_valid_reg <= '0;
            slot_valid_reg[0] <= 1'b1;
            for (int i = 0; i < N_USERS; i++) begin
                slot_code_reg[i] <= (i == 0) ? INIT_W : '0;
            end
        end else if (slot_write) begin
            for (int i = 0; i < N_USERS; i++) begin
                if (pend_slot_reg == UW'(i)) begin
                    slot_code_reg[i]  <= pend_code_reg;
                    slot_valid_reg[i] <= (pend_code_reg != '0);
                end
            end
        end
    end

    // State register and all registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg       <= S_IDLE;
            timer_reg       <= '0;
            fail_reg        <= '0;
            level_reg       <= '0;
            auth_id_reg     <= '0;
            auth_master_reg <= 1'b0;
            pend_slot_reg   <= '0;
            pend_code_reg   <= '0;
            unlock_reg      <= 1'b0;
            alarm_reg       <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            state_reg       <= state_next;
            timer_reg       <= timer_next;
            fail_reg        <= fail_next;
            level_reg       <= level_next;
            auth_id_reg     <= auth_id_next;
            auth_master_reg <= auth_master_next;
            pend_slot_reg   <= pend_slot_next;
            pend_code_reg   <= pend_code_next;
            unlock_reg      <= unlock_next;
            alarm_reg       <= alarm_next;
            err_reg         <= err_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        timer_next       = (timer_reg == TW'(TMAX)) ? timer_reg : timer_reg + TW'(1);
        fail_next        = fail_reg;
        level_next       = level_reg;
        auth_id_next     = auth_id_reg;
        auth_master_next = auth_master_reg;
        pend_slot_next   = pend_slot_reg;
        pend_code_next   = pend_code_reg;
        case (state_reg)
            S_IDLE: begin
                if (code_valid) begin
                    if (master_hit || match_any) begin
                        state_next       = S_MENU;
                        fail_next        = '0;
                        level_next       = '0;
                        auth_master_next = master_hit;
                        auth_id_next     = master_hit ? '0 : match_idx;
                    end else begin
                        fail_next = fail_inc;
                        if (fail_inc == FW'(MAX_FAILS)) begin
                            state_next = S_ALARM;
                        end
                    end
                end
            end
            S_ALARM: begin
                if (timer_reg == alarm_len - TW'(1)) begin
                    state_next = S_IDLE;
                    fail_next  = '0;
                    level_next = (level_reg == 2'd2) ? 2'd2 : level_reg + 2'd1;
                end
            end
            S_MENU: begin
                if (exit_req) begin
                    state_next = S_IDLE;
                end else if (unlock_req) begin
                    state_next = S_UNLOCKED;
                end else if (change_req) begin
                    if (change_ok) begin
                        state_next     = S_CHANGE;
                        pend_slot_next = slot_sel;
                        pend_code_next = new_code;
                    end
                end else if (timer_reg == TW'(MENU_TIMEOUT - 1)) begin
                    state_next = S_IDLE;
                end
                if (any_req) begin
                    timer_next = '0;
                end
            end
            S_CHANGE: begin
                state_next = S_MENU;
            end
            S_UNLOCKED: begin
                if (timer_reg == TW'(UNLOCK_CYCLES - 1)) begin
                    state_next = S_IDLE;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
        // Every state's interval counts from zero on entry.
        if (state_next != state_reg || state_reg == S_IDLE) begin
            timer_next = '0;
        end
    end

    always_comb begin
        unlock_next = (state_next == S_UNLOCKED);
        alarm_next  = (state_next == S_ALARM);
        err_next    = 1'b0;
        if (state_reg == S_MENU && !exit_req && !unlock_req && change_req && !change_ok) begin
            err_next = 1'b1;
        end
        if (state_reg == S_CHANGE && pend_code_reg == MASTER_W) begin
            err_next = 1'b1;
        end
    end

    assign unlock_signal = unlock_reg;
    assign lock_signal   = ~unlock_reg;
    assign alarm_signal  = alarm_reg;
    assign state         = state_reg;
    assign fail_count    = fail_reg;
    assign auth_id       = auth_id_reg;
    assign auth_master   = auth_master_reg;
    assign err           = err_reg;

endmodule

// File: tb/tb_door_access_ctrl.sv
// Directed bench for door_access_ctrl: authentication, unlock, slot changes,
// alarm escalation, menu timeout and mid-operation reset.
module tb_door_access_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        code_valid;
    logic [13:0] code_in;
    logic        unlock_req;
    logic        change_req;
    logic        exit_req;
    logic [1:0]  slot_sel;
    logic [13:0] new_code;
    logic        unlock_signal;
    logic        lock_signal;
    logic        alarm_signal;
    logic [2:0]  state;
    logic [1:0]  fail_count;
    logic [1:0]  auth_id;
    logic        auth_master;
    logic        err;

    int n_checks = 0;
    int n_pass   = 0;

    door_access_ctrl dut (
        .clk(clk), .reset(reset), .code_valid(code_valid), .code_in(code_in),
        .unlock_req(unlock_req), .change_req(change_req), .exit_req(exit_req),
        .slot_sel(slot_sel), .new_code(new_code), .unlock_signal(unlock_signal),
        .lock_signal(lock_signal), .alarm_signal(alarm_signal), .state(state),
        .fail_count(fail_count), .auth_id(auth_id), .auth_master(auth_master), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter_code(input logic [13:0] c);
        code_valid = 1'b1;
        code_in    = c;
        tick();
        code_valid = 1'b0;
        $display("code %0d -> state %0d fail %0d id %0d master %0d", c, state, fail_count, auth_id, auth_master);
    endtask

    task automatic do_exit();
        exit_req = 1'b1;
        tick();
        exit_req = 1'b0;
        $display("exit -> state %0d", state);
    endtask

    task automatic do_unlock();
        unlock_req = 1'b1;
        tick();
        unlock_req = 1'b0;
        $display("unlock -> state %0d unlock %0d", state, unlock_signal);
    endtask

    task automatic do_change(input logic [1:0] s, input logic [13:0] c);
        change_req = 1'b1;
        slot_sel   = s;
        new_code   = c;
        tick();
        change_req = 1'b0;
        $display("change slot %0d to %0d -> state %0d err %0d", s, c, state, err);
    endtask

    // Cycles a signal stays high: 0 unlock, 1 alarm, 2 state==MENU. Bounded.
    task automatic measure(input int which, output int n);
        n = 0;
        while (n < 300) begin
            if (which == 0 && !unlock_signal) break;
            if (which == 1 && !alarm_signal) break;
            if (which == 2 && state != 3'd1) break;
            n++;
            tick();
        end
        $display("measure %0d -> %0d cycles", which, n);
    endtask

    task automatic alarm_round(input string tag, input int exp_len);
        int n;
        enter_code(14'd3333);
        check({tag, "_f1"}, fail_count, 1);
        enter_code(14'd3333);
        check({tag, "_f2"}, fail_count, 2);
        enter_code(14'd3333);
        check({tag, "_st"}, state, 3);
        check({tag, "_fail3"}, fail_count, 3);
        measure(1, n);
        check({tag, "_len"}, n, exp_len);
        check({tag, "_end_st"}, state, 0);
        check({tag, "_end_fail"}, fail_count, 0);
    endtask

    initial begin
        int n;
        reset = 1'b1; code_valid = 0; code_in = 0; unlock_req = 0;
        change_req = 0; exit_req = 0; slot_sel = 0; new_code = 0;
        tick(); tick();
        reset = 1'b0;

        check("rst_state", state, 0);
        check("rst_lock", lock_signal, 1);
        check("rst_unlock", unlock_signal, 0);
        check("rst_alarm", alarm_signal, 0);
        check("rst_fail", fail_count, 0);
        check("rst_id", auth_id, 0);
        check("rst_master", auth_master, 0);
        check("rst_err", err, 0);

        // Initial code, unlock pulse length
        enter_code(14'd1234);
        check("init_menu", state, 1);
        check("init_id", auth_id, 0);
        check("init_master", auth_master, 0);
        do_unlock();
        check("unl_state", state, 2);
        check("unl_lock", lock_signal, 0);
        measure(0, n);
        check("unl_len", n, 8);
        check("unl_idle", state, 0);
        check("unl_relock", lock_signal, 1);

        // Master programs slot 2
        enter_code(14'd1111);
        check("mst_menu", state, 1);
        check("mst_flag", auth_master, 1);
        do_change(2'd2, 14'd2222);
        check("chg_state", state, 4);
        tick();
        check("chg_back", state, 1);
        check("chg_noerr", err, 0);
        do_exit();
        check("exit_idle", state, 0);
        enter_code(14'd2222);
        check("s2_menu", state, 1);
        check("s2_id", auth_id, 2);
        check("s2_master", auth_master, 0);
        do_exit();

        // Unauthorised change and master-key write rejected
        enter_code(14'd1234);
        do_change(2'd1, 14'd5555);
        check("rej_state", state, 1);
        check("rej_err", err, 1);
        tick();
        check("rej_err_clr", err, 0);
        do_exit();
        enter_code(14'd5555);
        check("s1_unchanged", fail_count, 1);
        enter_code(14'd1111);
        check("mk_fail_clr", fail_count, 0);
        do_change(2'd0, 14'd1111);
        check("mk_chg", state, 4);
        tick();
        check("mk_err", err, 1);
        check("mk_menu", state, 1);
        tick();
        check("mk_err_clr", err, 0);
        do_exit();
        enter_code(14'd1234);
        check("s0_kept", state, 1);
        do_exit();

        // Alarm escalation; code_valid during alarm ignored
        enter_code(14'd3333);
        enter_code(14'd3333);
        enter_code(14'd3333);
        check("al0_st", state, 3);
        enter_code(14'd1234);
        check("al0_ign", state, 3);
        measure(1, n);
        check("al0_len", n + 1, 16);
        alarm_round("al1", 32);
        alarm_round("al2", 64);
        alarm_round("al3", 64);
        enter_code(14'd1234);
        check("lvl_clr_menu", state, 1);
        do_exit();
        alarm_round("al4", 16);

        // Menu timeout
        enter_code(14'd1234);
        measure(2, n);
        check("to_len", n, 32);
        check("to_idle", state, 0);

        // code_valid during unlock ignored
        enter_code(14'd1234);
        do_unlock();
        enter_code(14'd3333);
        check("unl_ign_st", state, 2);
        check("unl_ign_fail", fail_count, 0);
        measure(0, n);
        check("unl_ign_len", n + 1, 8);

        // Lowest slot wins on duplicate codes, then reset mid-unlock
        enter_code(14'd1111);
        do_change(2'd1, 14'd2222);
        tick();
        do_exit();
        enter_code(14'd2222);
        check("dup_id", auth_id, 1);
        do_unlock();
        tick(); tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("mrst_state", state, 0);
        check("mrst_lock", lock_signal, 1);
        check("mrst_unlock", unlock_signal, 0);
        enter_code(14'd2222);
        check("mrst_slot_clr", fail_count, 1);
        check("mrst_slot_st", state, 0);
        enter_code(14'd1234);
        check("mrst_init", state, 1);
        check("mrst_id", auth_id, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
